// File: rtl/ebus_diag_reader.sv
// EBUS diagnostic reader: drives a diag read function, waits for the bus to settle,
// and captures one word (single mode) or all eight selects into a scan buffer.
module ebus_diag_reader #(
  parameter int SETTLE = 2,
  parameter int TMO    = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        scan,
  input  logic [3:0]  func,
  input  logic [2:0]  sel,
  input  logic [0:35] ebus_data,
  input  logic        ebus_driving,
  input  logic [2:0]  rd_addr,
  output logic [6:0]  diag,
  output logic        diag_read,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  output logic [0:35] data,
  output logic [0:35] rd_data
);

  localparam int DATA_W = 36;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_SETTLE,
    S_CAPTURE,
    S_NEXT,
    S_DONE
  } state_t;

  state_t state, state_nx;

  logic [3:0]        func_q;
  logic [2:0]        sel_q;
  logic              scan_q;
  logic [3:0]        settle_cnt;
  logic [3:0]        tmo_cnt;
  logic              miss;
  logic              miss_now;
  logic              settled;
  logic [0:DATA_W-1] cap_word;
  logic [0:DATA_W-1] buffer [8];

  function automatic logic [3:0] sat_dec(input logic [3:0] v);
    return (v == 4'd0) ? 4'd0 : v - 4'd1;
  endfunction

  assign settled  = (settle_cnt == 4'd0) && ebus_driving;
  assign miss_now = (state == S_SETTLE) && !ebus_driving && (tmo_cnt == 4'd0);
  // A select nobody answered is recorded as zero rather than whatever floats on the bus.
  assign cap_word = miss ? '0 : ebus_data;

  always_comb begin
    state_nx  = state;
    diag_read = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_nx = S_DRIVE;
      end
      S_DRIVE: begin
        diag_read = 1'b1;
        state_nx  = S_SETTLE;
      end
      S_SETTLE: begin
        diag_read = 1'b1;
        if (settled || miss_now) state_nx = S_CAPTURE;
      end
      S_CAPTURE: begin
        diag_read = 1'b1;
        state_nx  = S_NEXT;
      end
      S_NEXT: begin
        // diag_read drops here so each select sees a fresh function edge.
        if (scan_q && (sel_q != 3'd7)) state_nx = S_DRIVE;
        else                           state_nx = S_DONE;
      end
      S_DONE: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: begin
        busy     = 1'b0;
        state_nx = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      func_q     <= '0;
      sel_q      <= '0;
      scan_q     <= 1'b0;
      settle_cnt <= '0;
      tmo_cnt    <= '0;
      miss       <= 1'b0;
      timeout    <= 1'b0;
      data       <= '0;
      for (int i = 0; i < 8; i++) buffer[i] <= '0;
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE: begin
          if (start) begin
            func_q  <= func;
            sel_q   <= scan ? 3'd0 : sel;
            scan_q  <= scan;
            timeout <= 1'b0;
          end
        end
        S_DRIVE: begin
          settle_cnt <= 4'(SETTLE - 1);
          tmo_cnt    <= 4'(TMO - 1);
          miss       <= 1'b0;
        end
        S_SETTLE: begin
          settle_cnt <= sat_dec(settle_cnt);
          if (!ebus_driving) tmo_cnt <= sat_dec(tmo_cnt);
          if (miss_now) begin
            miss    <= 1'b1;
            timeout <= 1'b1;
          end
        end
        S_CAPTURE: begin
          data <= cap_word;
          if (scan_q) buffer[sel_q] <= cap_word;
        end
        S_NEXT: begin
          if (scan_q && (sel_q != 3'd7)) sel_q <= sel_q + 3'd1;
        end
        default: ;
      endcase
    end
  end

  assign diag    = {func_q, sel_q};
  assign rd_data = buffer[rd_addr];

endmodule

// File: tb/tb_ebus_diag_reader.sv
// Directed bench for ebus_diag_reader: single reads, scans, missing drivers and mid-scan reset.
module tb_ebus_diag_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        scan;
  logic [3:0]  func;
  logic [2:0]  sel;
  logic [0:35] ebus_data;
  logic        ebus_driving;
  logic [2:0]  rd_addr;
  logic [6:0]  diag;
  logic        diag_read;
  logic        busy;
  logic        done;
  logic        timeout;
  logic [0:35] data;
  logic [0:35] rd_data;

  int checks = 0;
  int errors = 0;
  int done_seen = 0;

  // Bus driver model: answers while diag_read is up unless disabled for the current select.
  logic        drv_on;
  logic [7:0]  absent;
  logic        word_mode;
  logic [0:35] fixed_word;
  localparam logic [0:35] STEP = 36'o010101010101;

  assign ebus_driving = diag_read && drv_on && !absent[diag[2:0]];
  assign ebus_data    = !ebus_driving ? 36'o777777777777 :
                        word_mode ? 36'(diag[2:0]) * STEP : fixed_word;

  ebus_diag_reader #(.SETTLE(2), .TMO(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .scan         (scan),
    .func         (func),
    .sel          (sel),
    .ebus_data    (ebus_data),
    .ebus_driving (ebus_driving),
    .rd_addr      (rd_addr),
    .diag         (diag),
    .diag_read    (diag_read),
    .busy         (busy),
    .done         (done),
    .timeout      (timeout),
    .data         (data),
    .rd_data      (rd_data)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done) done_seen++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s observed %0o expected %0o", tag, obs, exp);
    end
  endtask

  // Issues one request and follows it to done; lat is the negedge index of done (0 if never).
  task automatic run_op(input logic s, input logic [3:0] f, input logic [2:0] sl,
                        output int lat, output int rises, output int lows, output int dbad);
    logic prev;
    @(negedge clk);
    start = 1'b1; scan = s; func = f; sel = sl;
    prev = 1'b0; rises = 0; lows = 0; dbad = 0; lat = 0;
    for (int n = 1; n <= 300; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (diag_read && !prev) rises++;
      if (!diag_read) lows++;
      if (diag_read && ((diag[6:3] !== f) || (!s && diag[2:0] !== sl))) dbad++;
      prev = diag_read;
      if (done) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic check_buffer(input string tag, input logic [7:0] zero_mask);
    logic [0:35] exp;
    for (int k = 0; k < 8; k++) begin
      rd_addr = 3'(k);
      #1;
      exp = zero_mask[k] ? 36'o0 : 36'(k) * STEP;
      chk($sformatf("%s_buf%0d", tag, k), rd_data, exp);
    end
  endtask

  initial begin
    int lat, rises, lows, dbad, d0;
    rst_n = 1'b0; start = 1'b0; scan = 1'b0; func = '0; sel = '0; rd_addr = '0;
    drv_on = 1'b1; absent = '0; word_mode = 1'b0; fixed_word = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_diag_read", diag_read, 1'b0);
    chk("rst_diag", diag, 7'o0);
    chk("rst_timeout", timeout, 1'b0);
    chk("rst_data", data, 36'o0);
    check_buffer("rst", 8'hFF);
    rst_n = 1'b1;

    // Single read, driver present
    fixed_word = 36'o123456701234;
    run_op(1'b0, 4'b1101, 3'd3, lat, rises, lows, dbad);
    chk("single_lat", lat, 6);
    chk("single_diag", diag, 7'o153);
    chk("single_data", data, 36'o123456701234);
    chk("single_timeout", timeout, 1'b0);
    chk("single_rises", rises, 1);
    chk("single_diag_stable", dbad, 0);
    @(negedge clk);
    chk("single_busy_after", busy, 1'b0);
    chk("single_done_after", done, 1'b0);
    rd_addr = 3'd3; #1;
    chk("single_no_buf_write", rd_data, 36'o0);

    // Full scan
    word_mode = 1'b1;
    d0 = done_seen;
    run_op(1'b1, 4'b0110, 3'd5, lat, rises, lows, dbad);
    chk("scan_lat", lat, 41);
    chk("scan_rises", rises, 8);
    chk("scan_lows", lows, 9);
    chk("scan_diag_func", dbad, 0);
    chk("scan_data", data, 36'o070707070707);
    chk("scan_timeout", timeout, 1'b0);
    repeat (3) @(negedge clk);
    chk("scan_one_done", done_seen - d0, 1);
    check_buffer("scan", 8'h01);

    // No driver, single read
    word_mode = 1'b0; drv_on = 1'b0;
    run_op(1'b0, 4'b0011, 3'd5, lat, rises, lows, dbad);
    chk("nodrv_lat", lat, 12);
    chk("nodrv_timeout", timeout, 1'b1);
    chk("nodrv_data", data, 36'o0);
    drv_on = 1'b1; fixed_word = 36'o765432107654;
    run_op(1'b0, 4'b0011, 3'd1, lat, rises, lows, dbad);
    chk("clr_lat", lat, 6);
    chk("clr_timeout", timeout, 1'b0);
    chk("clr_data", data, 36'o765432107654);

    // Scan with select 4 unanswered
    word_mode = 1'b1; absent = 8'h10;
    run_op(1'b1, 4'b1001, 3'd0, lat, rises, lows, dbad);
    chk("miss4_lat", lat, 47);
    chk("miss4_timeout", timeout, 1'b1);
    chk("miss4_data", data, 36'o070707070707);
    check_buffer("miss4", 8'h11);
    absent = '0;

    // Start while busy, then reset during select 2 settle
    repeat (2) @(negedge clk);
    d0 = done_seen;
    @(negedge clk);
    start = 1'b1; scan = 1'b1; func = 4'b1010; sel = 3'd0;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      start = (n == 3);
      if (n == 3) begin scan = 1'b0; func = 4'b0001; sel = 3'd6; end
      if (n == 8) begin
        chk("busy_start_diag", diag, {4'b1010, 3'd1});
        chk("busy_start_busy", busy, 1'b1);
      end
    end
    chk("pre_rst_sel", diag[2:0], 3'd2);
    chk("pre_rst_diag_read", diag_read, 1'b1);
    chk("pre_rst_data", data, 36'o010101010101);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_diag_read", diag_read, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_diag", diag, 7'o0);
    chk("abort_data", data, 36'o0);
    chk("abort_timeout", timeout, 1'b0);
    check_buffer("abort", 8'hFF);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("abort_no_done", done_seen - d0, 0);
    chk("abort_idle", busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
